// File: rtl/popcount_neuron_sched_if.sv
// Handshake and data bundle for the ternary-neuron popcount sequencer.
// Carries the operand request, the result response and the shared popcount link.
// slave = sequencer side, master = requester / popcount-unit side.
interface popcount_neuron_sched_if #(
  parameter int N_CHUNKS = 4,
  parameter int ACC_W    = 7
);
  // Operand request
  logic                           in_valid;
  logic                           in_ready;
  logic [11*N_CHUNKS-1:0]         in_x;
  logic [11*N_CHUNKS-1:0]         in_wpos;
  logic [11*N_CHUNKS-1:0]         in_wneg;
  logic signed [ACC_W-1:0]        in_thr;
  // Shared popcount unit, combinational round trip
  logic [10:0]                    pc_in;
  logic [3:0]                     pc_out;
  // Result response
  logic                           out_valid;
  logic                           out_ready;
  logic signed [ACC_W-1:0]        out_sum;
  logic                           out_act;
  logic                           busy;

  modport slave (
    input  in_valid, in_x, in_wpos, in_wneg, in_thr, pc_out, out_ready,
    output in_ready, pc_in, out_valid, out_sum, out_act, busy
  );

  modport master (
    output in_valid, in_x, in_wpos, in_wneg, in_thr, pc_out, out_ready,
    input  in_ready, pc_in, out_valid, out_sum, out_act, busy
  );
endinterface

// File: rtl/popcount_neuron_sched.sv
// Ternary neuron sequencer time-multiplexing one external popcount11 unit over N_CHUNKS chunks.
// Latency: result valid 2*N_CHUNKS cycles after accept; one operand set in flight at a time.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
// Ports: clk/rst (sync, active-high); bus (slave) carries in_* request, pc_in/pc_out popcount
// link, out_* response and busy.
module popcount_neuron_sched #(
  parameter int N_CHUNKS = 4,
  parameter int ACC_W    = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  popcount_neuron_sched_if.slave  bus
);

  localparam int W     = 11 * N_CHUNKS;
  localparam int CNT_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_CHUNKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_POS, S_NEG, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [W-1:0]            r_x;
  logic [W-1:0]            r_mpos;
  logic [W-1:0]            r_mneg;
  logic signed [ACC_W-1:0] r_thr;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_out_sum;
  logic                    r_out_act;
  logic [CNT_W-1:0]        r_chunk;

  logic [10:0]             w_x_chunk;
  logic [10:0]             w_mpos_chunk;
  logic [10:0]             w_mneg_chunk;
  logic [10:0]             w_pc_in;
  logic signed [ACC_W-1:0] w_pc_ext;
  logic signed [ACC_W-1:0] w_acc_pos;
  logic signed [ACC_W-1:0] w_acc_neg;
  logic                    w_in_ready;
  logic                    w_busy;

  // Chunk mux written as a constant-index loop so every slice is static.
  always_comb begin
    w_x_chunk    = '0;
    w_mpos_chunk = '0;
    w_mneg_chunk = '0;
    for (int k = 0; k < N_CHUNKS; k++) begin
      if (r_chunk == CNT_W'(k)) begin
        w_x_chunk    = r_x[11*k +: 11];
        w_mpos_chunk = r_mpos[11*k +: 11];
        w_mneg_chunk = r_mneg[11*k +: 11];
      end
    end
  end

  // pc_out is unsigned 0..15; zero-extend before signed accumulation.
  assign w_pc_ext  = ACC_W'(bus.pc_out);
  assign w_acc_pos = r_acc + w_pc_ext;
  assign w_acc_neg = r_acc - w_pc_ext;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_busy      = 1'b0;
    w_pc_in     = '0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = S_POS;
      end
      S_POS: begin
        w_busy      = 1'b1;
        w_pc_in     = w_x_chunk & w_mpos_chunk;
        w_state_nxt = S_NEG;
      end
      S_NEG: begin
        w_busy      = 1'b1;
        w_pc_in     = w_x_chunk & w_mneg_chunk;
        w_state_nxt = (r_chunk == LAST) ? S_DONE : S_POS;
      end
      S_DONE: begin
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Masks are resolved at capture: a bit set in both wpos and wneg lands in neither.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x       <= '0;
      r_mpos    <= '0;
      r_mneg    <= '0;
      r_thr     <= '0;
      r_acc     <= '0;
      r_chunk   <= '0;
      r_out_sum <= '0;
      r_out_act <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_x     <= bus.in_x;
            r_mpos  <= bus.in_wpos & ~bus.in_wneg;
            r_mneg  <= bus.in_wneg & ~bus.in_wpos;
            r_thr   <= bus.in_thr;
            r_acc   <= '0;
            r_chunk <= '0;
          end
        end
        S_POS: r_acc <= w_acc_pos;
        S_NEG: begin
          r_acc <= w_acc_neg;
          if (r_chunk == LAST) begin
            // Result registered on entry to DONE so it is stable for the whole hold.
            r_out_sum <= w_acc_neg;
            r_out_act <= (w_acc_neg >= r_thr);
          end else begin
            r_chunk <= r_chunk + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = w_busy;
  assign bus.pc_in     = w_pc_in;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_sum   = r_out_sum;
  assign bus.out_act   = r_out_act;

endmodule

// File: tb/tb_popcount_neuron_sched.sv
// Directed bench for popcount_neuron_sched with a behavioural popcount unit
// (exact, constant-15 stub, or exact with a per-phase error of -1/0/+1).
module tb_popcount_neuron_sched;
  localparam int NC = 4;
  localparam int AW = 7;
  localparam int W  = 11 * NC;
  localparam logic [W-1:0] ALL  = '1;
  localparam logic [W-1:0] ZERO = '0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  popcount_neuron_sched_if #(.N_CHUNKS(NC), .ACC_W(AW)) bus();

  popcount_neuron_sched #(.N_CHUNKS(NC), .ACC_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int mode     = 0;  // 0 exact, 1 stub 15, 2 exact + err[phase]
  int err [2*NC];
  int ph;

  // Phase index counted by the bench: 0..2*NC-1 across busy cycles.
  always @(posedge clk) begin
    if (rst || !bus.busy) ph <= 0;
    else                  ph <= ph + 1;
  end

  always_comb begin
    int c;
    c = $countones(bus.pc_in);
    if (mode == 1)      c = 15;
    else if (mode == 2) c = c + err[ph];
    if (c < 0)  c = 0;
    if (c > 15) c = 15;
    bus.pc_out = 4'(c);
  end

  function automatic int clamp15(input int v);
    if (v < 0)  return 0;
    if (v > 15) return 15;
    return v;
  endfunction

  function automatic int ref_sum(input logic [W-1:0] x, input logic [W-1:0] wp,
                                 input logic [W-1:0] wn);
    int s, p, n;
    logic [W-1:0] mp, mn;
    s  = 0;
    mp = wp & ~wn;
    mn = wn & ~wp;
    for (int k = 0; k < NC; k++) begin
      p = $countones(x[11*k +: 11] & mp[11*k +: 11]);
      n = $countones(x[11*k +: 11] & mn[11*k +: 11]);
      if (mode == 1) begin
        p = 15;
        n = 15;
      end else if (mode == 2) begin
        p = clamp15(p + err[2*k]);
        n = clamp15(n + err[2*k+1]);
      end
      s = s + p - n;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ends at the falling edge right after the accepting rising edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] wp,
                      input logic [W-1:0] wn, input int thr);
    @(negedge clk);
    chk("in_ready_before_send", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_wpos  = wp;
    bus.in_wneg  = wn;
    bus.in_thr   = AW'(thr);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic await_result(input string tag, input int exp_sum, input logic exp_act,
                              input bit zero_pc);
    int k;
    k = 0;
    while (!bus.out_valid && k < 50) begin
      chk({tag, "_busy"}, bus.busy, 1);
      if (zero_pc) chk({tag, "_pc_in_zero"}, bus.pc_in, 0);
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, k, 2*NC);
    chk({tag, "_sum"}, bus.out_sum, exp_sum);
    chk({tag, "_act"}, bus.out_act, exp_act);
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("release_out_valid", bus.out_valid, 0);
    chk("release_in_ready", bus.in_ready, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_sum"}, bus.out_sum, 0);
    chk({tag, "_out_act"}, bus.out_act, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_pc_in"}, bus.pc_in, 0);
  endtask

  // Global bound so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected TB_RESULT before 200000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // chunks ordered {c3,c2,c1,c0}
    // v1: c0 +4-4, c1 +8, c2 -2 -> 6
    // v2: c0 overlap 0FF/0F0 leaves +4 only, c1 +8, c2 -2 -> 10
    logic [W-1:0] v1_x, v1_p, v1_n, v2_p, v2_n, rx, rp, rn;
    int thr, es;
    v1_x = {11'h000, 11'h7FF, 11'h0FF, 11'h7FF};
    v1_p = {11'h000, 11'h000, 11'h7FF, 11'h00F};
    v1_n = {11'h000, 11'h003, 11'h000, 11'h0F0};
    v2_p = {11'h000, 11'h000, 11'h7FF, 11'h0FF};
    v2_n = {11'h000, 11'h003, 11'h000, 11'h0F0};

    for (int i = 0; i < 2*NC; i++) err[i] = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_wpos   = '0;
    bus.in_wneg   = '0;
    bus.in_thr    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // All positive, all negative, threshold boundary
    send(ALL, ALL, ZERO, 40);
    await_result("pos_all", 44, 1'b1, 1'b0);
    release_out();
    send(ALL, ZERO, ALL, -44);
    await_result("neg_all_thr_m44", -44, 1'b1, 1'b0);
    release_out();
    send(ALL, ZERO, ALL, -43);
    await_result("neg_all_thr_m43", -44, 1'b0, 1'b0);
    release_out();

    // Mixed chunks, including overlapping mask bits
    send(v1_x, v1_p, v1_n, 6);
    await_result("mixed_v1", 6, 1'b1, 1'b0);
    release_out();
    send(v1_x, v2_p, v2_n, 11);
    await_result("mixed_v2_overlap", 10, 1'b0, 1'b0);
    release_out();

    // Both masks set everywhere: every weight is zero
    rx = W'({$urandom(), $urandom()});
    send(rx, ALL, ALL, 0);
    await_result("cancel_all", 0, 1'b1, 1'b1);
    release_out();

    // Hold in DONE for 5 cycles with in_valid offered meanwhile
    send(v1_x, v1_p, v1_n, 6);
    await_result("hold_a", 6, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.in_valid = 1'b1;
        bus.in_x     = ALL;
        bus.in_wpos  = ZERO;
        bus.in_wneg  = ALL;
        bus.in_thr   = AW'(0);
      end else if (i == 2) begin
        bus.in_valid = 1'b0;
      end else if (i >= 3) begin
        bus.in_valid = 1'b1;
        bus.in_x     = ALL;
        bus.in_wpos  = ALL;
        bus.in_wneg  = ZERO;
        bus.in_thr   = AW'(40);
      end
      @(posedge clk);
      @(negedge clk);
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_out_sum", bus.out_sum, 6);
      chk("hold_out_act", bus.out_act, 1);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_busy", bus.busy, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("hold_idle_out_valid", bus.out_valid, 0);
    chk("hold_idle_in_ready", bus.in_ready, 1);
    chk("hold_idle_busy", bus.busy, 0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    await_result("hold_b", 44, 1'b1, 1'b0);
    release_out();

    // Reset during NEG of chunk 2 (accept edge + 5 edges)
    send(ALL, ALL, ZERO, 40);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("abort_busy_before", bus.busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("abort");
    send(v1_x, v1_p, v1_n, 6);
    await_result("after_abort", 6, 1'b1, 1'b0);
    release_out();

    // Popcount stub returning 15 in every phase
    mode = 1;
    rx = W'({$urandom(), $urandom()});
    send(rx, ALL, ZERO, 0);
    await_result("stub15_thr0", 0, 1'b1, 1'b0);
    release_out();
    send(rx, ZERO, ALL, 1);
    await_result("stub15_thr1", 0, 1'b0, 1'b0);
    release_out();

    // Approximate popcount regression, error -1/0/+1 per phase
    mode = 2;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 2*NC; i++) err[i] = int'($urandom_range(0, 2)) - 1;
      rx  = W'({$urandom(), $urandom()});
      rp  = W'({$urandom(), $urandom()});
      rn  = W'({$urandom(), $urandom()});
      thr = int'($urandom_range(0, 127)) - 64;
      es  = ref_sum(rx, rp, rn);
      send(rx, rp, rn, thr);
      await_result("approx", es, (es >= thr), 1'b0);
      release_out();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
